data_mem_arbiter: RTL

- Shares the processor's single-port data memory between two requesters: the core load/store unit (scalar and VLEN-lane vector accesses) and the external parallel readback port (address in, 16-bit word out, enabled from the switches).
- Sequences vector accesses as consecutive-address bursts.
- Arbitrates with core priority plus a starvation guard, so the readback port always makes progress.

---
 rtl/data_mem_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares a single-port synchronous data memory between the core load/store
//   unit (scalar or VLEN-lane vector accesses) and the external readback port.
//   The core has priority. A starvation counter forces an external read after
//   STARVE_MAX consecutive core grants while the readback port is enabled.
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   core_req/we/vec      core request level, write flag, vector (VLEN burst) flag
//   core_addr/wdata      base word address, write lanes (lane i = [i*DATA_W +: DATA_W])
//   core_gnt/core_done   one-cycle grant / completion pulses
//   core_rdata           read lanes, stable from core_done until the next core read grant
//   ext_en/ext_addr      readback enable switch and address
//   ext_q/ext_valid      last readback word and its one-cycle update pulse
//   mem_addr/we/wdata    memory command (combinational from state, zero when idle)
//   mem_rdata            memory read data, valid the cycle after its address
//   busy                 high whenever the FSM is not in IDLE
//   dbg_state            current FSM state (IDLE=0, BURST=1, EXT_RD=2, WAIT=3)
//   dbg_starve_cnt       current starvation counter
//
// Handshake: core_req is a level. A grant consumes the request present at the
// grant edge and latches all request fields; if core_req is still high when the
// arbiter is back in IDLE (including the core_done cycle) it is a new request.
module data_mem_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int VLEN       = 6,
    parameter int STARVE_MAX = 8,
    localparam int CW        = $clog2(STARVE_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     core_req,
    input  logic                     core_we,
    input  logic                     core_vec,
    input  logic [ADDR_W-1:0]        core_addr,
    input  logic [DATA_W*VLEN-1:0]   core_wdata,
    output logic                     core_gnt,
    output logic                     core_done,
    output logic [DATA_W*VLEN-1:0]   core_rdata,
    input  logic                     ext_en,
    input  logic [ADDR_W-1:0]        ext_addr,
    output logic [DATA_W-1:0]        ext_q,
    output logic                     ext_valid,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic                     busy,
    output logic [1:0]               dbg_state,
    output logic [CW-1:0]            dbg_starve_cnt
);

    localparam int BW = $clog2(VLEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        EXT_RD = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t                  state, next_state;
    logic [BW-1:0]           beat, next_beat, last_beat;
    logic                    core_win, ext_win;

    logic [ADDR_W-1:0]       lat_addr;
    logic                    lat_we;
    logic                    lat_vec;
    logic [DATA_W*VLEN-1:0]  lat_wdata;
    logic [ADDR_W-1:0]       lat_ext_addr;
    logic                    lat_is_ext;
    logic [CW-1:0]           starve_cnt;

    // Read-return pipeline: data for a read beat appears one cycle later.
    logic                    rd_vld;
    logic [BW-1:0]           rd_lane;

    // Next-state logic and arbitration.
    always_comb begin
        next_state = state;
        next_beat  = beat;
        core_win   = 1'b0;
        ext_win    = 1'b0;
        last_beat  = lat_vec ? BW'(VLEN - 1) : '0;
        case (state)
            IDLE: begin
                if (ext_en && (!core_req || starve_cnt == CW'(STARVE_MAX))) begin
                    ext_win    = 1'b1;
                    next_state = EXT_RD;
                end else if (core_req) begin
                    core_win   = 1'b1;
                    next_state = BURST;
                    next_beat  = '0;
                end
            end
            BURST: begin
                if (beat == last_beat) next_state = WAIT;
                else                   next_beat  = beat + BW'(1);
            end
            EXT_RD:  next_state = WAIT;
            WAIT:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory command is decoded from state so that reset clears it at once.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state)
            BURST: begin
                mem_addr = lat_addr + ADDR_W'(beat);
                mem_we   = lat_we;
                if (lat_we) mem_wdata = lat_wdata[beat*DATA_W +: DATA_W];
            end
            EXT_RD:  mem_addr = lat_ext_addr;
            default: ;
        endcase
    end

    assign busy           = (state != IDLE);
    assign dbg_state      = state;
    assign dbg_starve_cnt = starve_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            beat         <= '0;
            lat_addr     <= '0;
            lat_we       <= 1'b0;
            lat_vec      <= 1'b0;
            lat_wdata    <= '0;
            lat_ext_addr <= '0;
            lat_is_ext   <= 1'b0;
            starve_cnt   <= '0;
            rd_vld       <= 1'b0;
            rd_lane      <= '0;
            core_gnt     <= 1'b0;
            core_done    <= 1'b0;
            core_rdata   <= '0;
            ext_q        <= '0;
            ext_valid    <= 1'b0;
        end else begin
            state <= next_state;
            beat  <= next_beat;

            if (core_win) begin
                lat_addr   <= core_addr;
                lat_we     <= core_we;
                lat_vec    <= core_vec;
                lat_wdata  <= core_wdata;
                lat_is_ext <= 1'b0;
            end
            if (ext_win) begin
                lat_ext_addr <= ext_addr;
                lat_is_ext   <= 1'b1;
            end

            // Counts core grants only while the readback port is waiting.
            if (!ext_en || ext_win)
                starve_cnt <= '0;
            else if (core_win && starve_cnt != CW'(STARVE_MAX))
                starve_cnt <= starve_cnt + CW'(1);

            core_gnt  <= core_win;
            core_done <= (state == WAIT) && !lat_is_ext;
            ext_valid <= (state == WAIT) && lat_is_ext;
            if (state == WAIT && lat_is_ext) ext_q <= mem_rdata;

            rd_vld  <= (state == BURST) && !lat_we;
            rd_lane <= beat;
            if (rd_vld) core_rdata[rd_lane*DATA_W +: DATA_W] <= mem_rdata;
        end
    end

endmodule
